sc_node_rr_arbiter: RTL and testbench
=====================================

# sc_node_rr_arbiter

Round-robin arbiter that shares one downstream SmartConnect node channel (req/send/recv/payld/info) among NUM_S upstream SC sources. Grant is locked for a whole packet and released on the beat whose payload LAST_BIT is set. The accepted beat is registered before it goes downstream. The block sits between per-source SC nodes (AW, AR or W channel) and a single shared master-side node, all in one clock domain.

## Interface

Parameters:
- NUM_S, 4: number of upstream sources, 2..16.
- PAYLD_W, 174: SC payload width (174 for AW/AR, 592 for W).
- INFO_W, 1: SC info width.
- LAST_BIT, 0: payload bit index that marks the final beat of a packet. Tie it to a constant-1 position for single-beat channels.

Ports:
- sc_aclk  in  1  clock.
- sc_aresetn  in  1  asynchronous active-low reset.
- s_sc_req  in  NUM_S  per-source request: source has a packet pending.
- s_sc_send  in  NUM_S  per-source beat valid.
- s_sc_payld  in  NUM_S*PAYLD_W  source i occupies bits [i*PAYLD_W +: PAYLD_W].
- s_sc_info  in  NUM_S*INFO_W  packed the same way as s_sc_payld.
- s_sc_recv  out  NUM_S  per-source beat accept; at most one bit set.
- m_sc_req  out  1  downstream request.
- m_sc_send  out  1  downstream beat valid.
- m_sc_payld  out  PAYLD_W  downstream payload (registered).
- m_sc_info  out  INFO_W  downstream info (registered).
- m_sc_recv  in  1  downstream accept.
- grant_idx  out  $clog2(NUM_S)  index of the current or last granted source.
- busy  out  1  high in XFER.

## Operation

State machine with states IDLE and XFER.

- **IDLE**
  - s_sc_recv = 0.
  - If any s_sc_req bit is set, pick the first requesting index searching upward from rr_ptr+1 (mod NUM_S).
  - Register that index into grant_idx and go to XFER.
- **XFER**
  - s_sc_recv[grant_idx] = accept_ok, where accept_ok = !out_full || m_sc_recv. All other recv bits are 0.
  - Upstream beat: s_sc_send[g] && s_sc_recv[g]. It loads out_payld/out_info and sets out_full.
  - An upstream beat with payld[LAST_BIT] = 1 sets rr_ptr = grant_idx and returns to IDLE.
- **Output register**
  - m_sc_send = out_full.
  - out_full clears on m_sc_send && m_sc_recv unless a new beat loads in the same cycle.
  - m_sc_req = busy || out_full.
- Grant is not revoked if the granted source drops s_sc_req mid-packet. Only the last beat ends the grant.
- Requests from non-granted sources have no effect until IDLE.
- No beat is ever dropped or duplicated. Beat order within a packet is preserved.

## Timing

- Reset values:
  - state = IDLE.
  - rr_ptr = NUM_S-1, so source 0 wins first.
  - grant_idx = 0, busy = 0, out_full = 0.
  - m_sc_send = 0, m_sc_req = 0, s_sc_recv = 0.
  - m_sc_payld = 0, m_sc_info = 0.
- Request to grant: req seen in IDLE at cycle N puts the block in XFER with recv asserted at N+1.
- Beat latency: a beat accepted at cycle N appears on m_sc_send at N+1.
- Throughput is 1 beat/cycle while m_sc_recv = 1.
- Packets cost one IDLE bubble between them.
- Full with m_sc_recv = 1: load and drain in the same cycle, out_full stays 1.
- Full with m_sc_recv = 0: s_sc_recv = 0 and the output holds stable.
- Single-beat packet (LAST_BIT set on the first beat): XFER lasts 1 cycle.
- Reset mid-packet: asynchronous clear to reset values. The in-flight output beat is discarded.

## Structure

- Shared package holds:
  - SC channel width constants (AW/AR 174, W 592, R 533, B 7).
  - State enum {IDLE, XFER}.
  - Function rr_pick(req, ptr) returning the index.
- Natural sub-module: sc_rr_pick, a combinational round-robin priority picker (req vector + pointer -> index, valid).
- Everything else stays in one module: FSM, output register, mux.

## Test plan

- **Reset:** hold sc_aresetn = 0 with all s_sc_req = 1 -> all outputs 0. Release -> source 0 granted one cycle later (grant_idx = 0, busy = 1).
- **Fairness:** sources 0..3 each request continuously with 2-beat packets -> grant order 0,1,2,3,0. Each packet is 2 consecutive m_sc_send beats with unchanged payload.
- **Lock:** source 1 sends a 4-beat packet while source 0 requests; source 1 drops s_sc_req after beat 1 -> all 4 beats from source 1 pass, then source 2/3/0 rotation resumes.
- **Backpressure:** hold m_sc_recv = 0 for 5 cycles mid-packet -> s_sc_recv = 0 after one buffered beat, m_sc_payld stable. On release there is no loss or duplication (scoreboard match).
- **Single-beat stream:** source 2 sends LAST=1 beats while others idle -> every other cycle accepted (IDLE bubble), latency 1 cycle each.
- **Mid-operation reset:** assert reset during beat 2 of 3 -> m_sc_send drops asynchronously. After release, arbitration restarts at source 0.

Source files
------------

// File: rtl/sc_node_rr_arbiter_pkg.sv
// Shared SC channel widths, arbiter state
// encoding and the round-robin pick helper.
package sc_node_rr_arbiter_pkg;

  localparam int SC_AW_W = 174;
  localparam int SC_AR_W = 174;
  localparam int SC_W_W  = 592;
  localparam int SC_R_W  = 533;
  localparam int SC_B_W  = 7;
  localparam int RR_MAX  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  // First set req bit searching upward from
  // ptr+1 (mod n). Walking the distance from
  // far to near lets the nearest hit win.
  function automatic int rr_pick(
    input logic [RR_MAX-1:0] req,
    input int                ptr,
    input int                n
  );
    int sel;
    int idx;
    sel = ptr;
    for (int k = RR_MAX; k >= 1; k--) begin
      if (k <= n) begin
        idx = (ptr + k) % n;
        if (req[idx[3:0]]) sel = idx;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/sc_node_rr_arbiter_if.sv
// SC node channel bundle, N lanes wide.
// master drives req/send/payld/info, slave drives recv.
interface sc_node_rr_arbiter_if
  import sc_node_rr_arbiter_pkg::*;
#(
  parameter int N       = 1,
  parameter int PAYLD_W = SC_AW_W,
  parameter int INFO_W  = 1
);

  logic [N-1:0]         req;
  logic [N-1:0]         send;
  logic [N-1:0]         recv;
  logic [N*PAYLD_W-1:0] payld;
  logic [N*INFO_W-1:0]  info;

  modport master (
    output req, send, payld, info,
    input  recv
  );

  modport slave (
    input  req, send, payld, info,
    output recv
  );

endinterface

// File: rtl/sc_node_rr_arbiter_pick.sv
// Combinational round-robin picker.
// req + ptr -> idx of next requester, valid.
module sc_rr_pick
  import sc_node_rr_arbiter_pkg::*;
#(
  parameter int NUM_S = 4,
  parameter int IW    = $clog2(NUM_S)
) (
  input  logic [NUM_S-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    idx,
  output logic             valid
);

  logic [RR_MAX-1:0] req_w;
  int                pick;

  always_comb begin
    req_w            = '0;
    req_w[NUM_S-1:0] = req;
    pick  = rr_pick(req_w, int'(ptr), NUM_S);
    idx   = IW'(pick);
    valid = |req;
  end

endmodule

// File: rtl/sc_node_rr_arbiter.sv
// Packet-locked round-robin arbiter of NUM_S SC
// sources onto one registered downstream node.
module sc_node_rr_arbiter
  import sc_node_rr_arbiter_pkg::*;
#(
  parameter int NUM_S    = 4,
  parameter int PAYLD_W  = SC_AW_W,
  parameter int INFO_W   = 1,
  parameter int LAST_BIT = 0,
  parameter int IW       = $clog2(NUM_S)
) (
  input  logic                sc_aclk,
  input  logic                sc_aresetn,
  sc_node_rr_arbiter_if.slave  s_sc,
  sc_node_rr_arbiter_if.master m_sc,
  output logic [IW-1:0]       grant_idx,
  output logic                busy
);

  arb_state_e state_q, state_d;

  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]      grant_q, grant_d;
  logic               out_full_q, out_full_d;
  logic [PAYLD_W-1:0] out_payld_q, out_payld_d;
  logic [INFO_W-1:0]  out_info_q, out_info_d;

  logic [IW-1:0]      pick_idx;
  logic               pick_vld;
  logic               accept_ok;
  logic               beat;
  logic [PAYLD_W-1:0] sel_payld;
  logic [INFO_W-1:0]  sel_info;

  sc_rr_pick #(
    .NUM_S (NUM_S),
    .IW    (IW)
  ) u_pick (
    .req   (s_sc.req),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  always_comb begin
    accept_ok   = !out_full_q || m_sc.recv[0];
    sel_payld   = s_sc.payld[grant_q*PAYLD_W +: PAYLD_W];
    sel_info    = s_sc.info[grant_q*INFO_W +: INFO_W];
    s_sc.recv   = '0;
    beat        = 1'b0;
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    out_full_d  = out_full_q;
    out_payld_d = out_payld_q;
    out_info_d  = out_info_q;

    if (out_full_q && m_sc.recv[0])
      out_full_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          state_d = XFER;
        end
      end
      XFER: begin
        s_sc.recv[grant_q] = accept_ok;
        beat = s_sc.send[grant_q] && accept_ok;
        // a new beat overrides the drain clear
        if (beat) begin
          out_full_d  = 1'b1;
          out_payld_d = sel_payld;
          out_info_d  = sel_info;
          if (sel_payld[LAST_BIT]) begin
            rr_ptr_d = grant_q;
            state_d  = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge sc_aclk or negedge sc_aresetn) begin
    if (!sc_aresetn) begin
      state_q     <= IDLE;
      rr_ptr_q    <= IW'(NUM_S - 1);
      grant_q     <= '0;
      out_full_q  <= 1'b0;
      out_payld_q <= '0;
      out_info_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      out_full_q  <= out_full_d;
      out_payld_q <= out_payld_d;
      out_info_q  <= out_info_d;
    end
  end

  assign busy       = (state_q == XFER);
  assign grant_idx  = grant_q;
  assign m_sc.send  = out_full_q;
  assign m_sc.req   = busy || out_full_q;
  assign m_sc.payld = out_payld_q;
  assign m_sc.info  = out_info_q;

endmodule

// File: tb/tb_sc_node_rr_arbiter.sv
// Scoreboard bench for sc_node_rr_arbiter:
// directed packets, monitor pops expected beats.
module tb_sc_node_rr_arbiter;
  import sc_node_rr_arbiter_pkg::*;

  localparam int NS = 4;
  localparam int PW = SC_AW_W;
  localparam int IW = $clog2(NS);

  typedef logic [PW-1:0] pw_t;

  logic          clk;
  logic          rst_n;
  logic          m_recv;
  logic [IW-1:0] grant_idx;
  logic          busy;
  int            cyc;
  int            n_cmp;
  int            n_bad;

  pw_t      srcq [NS][$];
  pw_t      exp_q[$];
  int       acc_n [NS];
  logic [NS-1:0] drop;
  logic [NS-1:0] started;

  sc_node_rr_arbiter_if #(
    .N(NS), .PAYLD_W(PW), .INFO_W(1)
  ) s_if ();
  sc_node_rr_arbiter_if #(
    .N(1), .PAYLD_W(PW), .INFO_W(1)
  ) m_if ();

  assign m_if.recv = m_recv;

  sc_node_rr_arbiter #(
    .NUM_S(NS), .PAYLD_W(PW),
    .INFO_W(1), .LAST_BIT(0)
  ) dut (
    .sc_aclk    (clk),
    .sc_aresetn (rst_n),
    .s_sc       (s_if),
    .m_sc       (m_if),
    .grant_idx  (grant_idx),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, pw_t act,
                     pw_t exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp_v);
    end
  endtask

  function automatic pw_t mk(int src, int seq,
                             bit last);
    pw_t p;
    p          = '0;
    p[0]       = last;
    p[7:1]     = 7'(seq);
    p[15:8]    = 8'(src);
    p[PW-1 -: 8] = 8'(src * 37 + seq);
    return p;
  endfunction

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      if (srcq[i].size() > 0) begin
        s_if.send[i]         = 1'b1;
        s_if.payld[i*PW +: PW] = srcq[i][0];
        s_if.info[i]         = srcq[i][0][1];
        s_if.req[i] = !(drop[i] && started[i]);
      end else begin
        s_if.send[i]         = 1'b0;
        s_if.payld[i*PW +: PW] = '0;
        s_if.info[i]         = 1'b0;
        s_if.req[i]          = 1'b0;
      end
    end
  endtask

  // load a packet; optionally expect it next
  task automatic pkt(int src, int n, int base,
                     bit expd);
    pw_t p;
    for (int b = 0; b < n; b++) begin
      p = mk(src, base + b, b == n - 1);
      srcq[src].push_back(p);
      if (expd) exp_q.push_back(p);
    end
  endtask

  function automatic int pend();
    int s;
    s = exp_q.size();
    for (int i = 0; i < NS; i++)
      s += srcq[i].size();
    return s;
  endfunction

  task automatic wait_idle(string nm, int maxc);
    int c;
    c = 0;
    while ((pend() != 0 || busy) && c < maxc) begin
      @(negedge clk);
      c++;
    end
    n_cmp++;
    if (c >= maxc) begin
      n_bad++;
      $display("FAIL %s: timeout pend=%0d",
               nm, pend());
    end
    repeat (2) @(negedge clk);
  endtask

  // source model: pop accepted beats
  initial begin
    logic [NS-1:0] acc;
    forever begin
      @(negedge clk);
      acc = s_if.recv & s_if.send;
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) begin
        if (acc[i] && srcq[i].size() > 0) begin
          started[i] = !srcq[i][0][0];
          void'(srcq[i].pop_front());
          acc_n[i]++;
        end
      end
      drive();
    end
  end

  // monitor: compare every downstream beat
  always @(negedge clk) begin
    pw_t e;
    if (rst_n && m_if.send[0] && m_recv) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL extra_beat: got %h",
                 m_if.payld);
      end else begin
        e = exp_q.pop_front();
        chk("beat_payld", m_if.payld, e);
        chk("beat_info", PW'(m_if.info), PW'(e[1]));
      end
    end
  end

  initial begin
    pw_t held;
    int  c;
    int  base;
    int  ac[$];
    int  oc[$];

    cyc     = 0;
    n_cmp   = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    m_recv  = 1'b1;
    drop    = '0;
    started = '0;
    for (int i = 0; i < NS; i++) acc_n[i] = 0;

    // reset with all sources requesting;
    // expected grant order 0,1,2,3,0
    pkt(0, 2, 0, 1);
    pkt(1, 2, 0, 1);
    pkt(2, 2, 0, 1);
    pkt(3, 2, 0, 1);
    pkt(0, 2, 2, 1);
    drive();
    repeat (3) @(negedge clk);
    chk("rst_send", PW'(m_if.send), '0);
    chk("rst_req", PW'(m_if.req), '0);
    chk("rst_recv", PW'(s_if.recv), '0);
    chk("rst_busy", PW'(busy), '0);
    chk("rst_grant", PW'(grant_idx), '0);
    chk("rst_payld", m_if.payld, '0);
    chk("rst_info", PW'(m_if.info), '0);

    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("first_grant", PW'(grant_idx), '0);
    chk("first_busy", PW'(busy), PW'(1));
    wait_idle("fair", 100);

    // lock: src1 drops req after beat 1;
    // order 1,2,3,0
    drop[1] = 1'b1;
    pkt(1, 4, 10, 1);
    pkt(2, 2, 10, 1);
    pkt(3, 2, 10, 1);
    pkt(0, 2, 10, 1);
    drive();
    wait_idle("lock", 100);
    drop[1] = 1'b0;

    // backpressure mid-packet
    pkt(1, 4, 20, 1);
    drive();
    c = 0;
    while (!m_if.send[0] && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("bp_start", PW'(c < 20), PW'(1));
    @(posedge clk);
    #1 m_recv = 1'b0;
    @(negedge clk);
    held = m_if.payld;
    repeat (5) begin
      @(negedge clk);
      chk("bp_recv", PW'(s_if.recv), '0);
      chk("bp_hold", m_if.payld, held);
      chk("bp_send", PW'(m_if.send), PW'(1));
    end
    @(posedge clk);
    #1 m_recv = 1'b1;
    wait_idle("bp", 100);

    // single-beat stream from source 2
    for (int b = 0; b < 4; b++)
      pkt(2, 1, 30 + b, 1);
    drive();
    c = 0;
    while (oc.size() < 4 && c < 60) begin
      @(negedge clk);
      c++;
      if (s_if.recv[2] && s_if.send[2])
        ac.push_back(cyc);
      if (m_if.send[0])
        oc.push_back(cyc);
    end
    chk("sb_count", PW'(ac.size() == 4 &&
        oc.size() == 4), PW'(1));
    if (ac.size() == 4 && oc.size() == 4) begin
      for (int i = 1; i < 4; i++)
        chk("sb_spacing",
            PW'(ac[i] - ac[i-1]), PW'(2));
      for (int i = 0; i < 4; i++)
        chk("sb_latency",
            PW'(oc[i] - ac[i]), PW'(1));
    end
    wait_idle("single", 60);

    // reset during beat 2 of a 3-beat packet
    pkt(3, 3, 40, 0);
    exp_q.push_back(mk(3, 40, 0));
    drive();
    base = acc_n[3];
    c = 0;
    do begin
      @(posedge clk);
      #2;
      c++;
    end while (acc_n[3] < base + 2 && c < 50);
    chk("mr_reach", PW'(c < 50), PW'(1));
    rst_n = 1'b0;
    #1;
    chk("mr_send", PW'(m_if.send), '0);
    chk("mr_req", PW'(m_if.req), '0);
    chk("mr_busy", PW'(busy), '0);
    chk("mr_sb", PW'(exp_q.size()), '0);
    for (int i = 0; i < NS; i++)
      srcq[i].delete();
    started = '0;
    exp_q.delete();
    pkt(0, 2, 50, 1);
    pkt(1, 2, 50, 1);
    drive();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mr_grant", PW'(grant_idx), '0);
    chk("mr_busy2", PW'(busy), PW'(1));
    wait_idle("mr", 100);

    chk("sb_empty", PW'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
